pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the team's combinational ripple adder. Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with registered carries between stages. Accepts one operation per cycle behind a valid/ready handshake and reports carry/borrow and signed overflow. Sits in the datapath wherever a wide add would otherwise break timing.

---
 rtl/adder_pkg.sv | 17 +
 rtl/chunk_adder.sv | 21 ++
 rtl/pipelined_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode encoding and stage-count helpers for pipelined_adder
package adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int stages_of(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit adder with carry-out and carry into its MSB
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    assign sum_o   = full[CHUNK-1:0];
    assign c_o     = full[CHUNK];
    // The carry into the top bit is recovered from the sum bit, which works for CHUNK = 1.
    assign c_msb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/sub resolved CHUNK bits per pipeline stage
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is a + ~b + ~c_in; the final carry is inverted into a borrow at the last stage.
    assign b_eff    = (mode_e'(sub) == MODE_SUB) ? ~b : b;
    assign cin_eff  = (mode_e'(sub) == MODE_SUB) ? ~c_in : c_in;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = (k + 1) * CHUNK;

        logic [CHUNK-1:0] a_s;
        logic [CHUNK-1:0] b_s;
        logic [CHUNK-1:0] s_s;
        logic             c_s;
        logic             co_s;
        logic             cm_s;
        logic             v_s;
        logic             sub_s;
        logic [DONE-1:0]  lo_d;
        logic [DONE-1:0]  lo_q;
        logic             v_q;

        if (k == 0) begin : g_src
            assign a_s   = a[CHUNK-1:0];
            assign b_s   = b_eff[CHUNK-1:0];
            assign c_s   = cin_eff;
            assign v_s   = in_valid;
            assign sub_s = sub;
            assign lo_d  = s_s;
        end else begin : g_src
            assign a_s   = g_stage[k-1].g_fwd.ha_q[CHUNK-1:0];
            assign b_s   = g_stage[k-1].g_fwd.hb_q[CHUNK-1:0];
            assign c_s   = g_stage[k-1].g_fwd.c_q;
            assign v_s   = g_stage[k-1].v_q;
            assign sub_s = g_stage[k-1].g_fwd.sub_q;
            assign lo_d  = {s_s, g_stage[k-1].lo_q};
        end

        chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a_i     (a_s),
            .b_i     (b_s),
            .c_i     (c_s),
            .sum_o   (s_s),
            .c_o     (co_s),
            .c_msb_o (cm_s)
        );

        // Valid bits and finished low slices advance together; bubbles move like data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= 1'b0;
                lo_q <= '0;
            end else if (en) begin
                v_q  <= v_s;
                lo_q <= lo_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int HI = WIDTH - DONE;

            logic [HI-1:0] ha_d;
            logic [HI-1:0] hb_d;
            logic [HI-1:0] ha_q;
            logic [HI-1:0] hb_q;
            logic          c_q;
            logic          sub_q;
            logic          unused_c_msb;

            assign unused_c_msb = cm_s;

            if (k == 0) begin : g_hi
                assign ha_d = a[WIDTH-1:CHUNK];
                assign hb_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_hi
                assign ha_d = g_stage[k-1].g_fwd.ha_q[HI+CHUNK-1:CHUNK];
                assign hb_d = g_stage[k-1].g_fwd.hb_q[HI+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ha_q  <= '0;
                    hb_q  <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                end else if (en) begin
                    ha_q  <= ha_d;
                    hb_q  <= hb_d;
                    c_q   <= co_s;
                    sub_q <= sub_s;
                end
            end
        end else begin : g_out
            logic co_q;
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    co_q  <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (en) begin
                    co_q  <= co_s ^ sub_s;
                    ovf_q <= cm_s ^ co_s;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].lo_q;
    assign carry_out = g_stage[STAGES-1].g_out.co_q;
    assign overflow  = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - random and directed checks of three pipelined_adder builds against an arithmetic model
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          acc;
        bit          lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             c_in;
    logic             sub;
    logic             out_ready;
    logic [2:0]       ir;
    logic [2:0]       ov;
    logic [2:0]       co;
    logic [2:0]       of;
    logic [2:0][15:0] sm;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ncyc    = 0;
    bit   lat_chk = 1'b0;
    int   stg [3] = '{4, 1, 16};
    exp_t sbq [3][$];

    logic [2:0]       held = '0;
    logic [2:0][15:0] h_sm;
    logic [2:0]       h_co;
    logic [2:0]       h_of;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .carry_out(co[0]), .overflow(of[0])
    );

    pipelined_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .carry_out(co[1]), .overflow(of[1])
    );

    pipelined_adder #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .carry_out(co[2]), .overflow(of[2])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    // Reference: true integer arithmetic, borrow as a negative difference, overflow as out-of-range signed result.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc, input logic ms);
        exp_t   e;
        longint ua, ub, sa, sb, r, sr;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (!ms) begin
            r    = ua + ub + longint'(mc);
            sr   = sa + sb + longint'(mc);
            e.co = (r >= 65536);
        end else begin
            r    = ua - ub - longint'(mc);
            sr   = sa - sb - longint'(mc);
            e.co = (r < 0);
        end
        e.s   = r[15:0];
        e.ov  = (sr > 32767) || (sr < -32768);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    always @(posedge rst) begin
        for (int i = 0; i < 3; i++) sbq[i].delete();
        held = '0;
    end

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d_in_ready", i), 32'(ir[i]), 32'(!ov[i] || out_ready));
                if (held[i]) begin
                    check($sformatf("u%0d_hold_valid", i), 32'(ov[i]), 32'd1);
                    check($sformatf("u%0d_hold_sum", i), 32'(sm[i]), 32'(h_sm[i]));
                    check($sformatf("u%0d_hold_flags", i), {30'd0, co[i], of[i]}, {30'd0, h_co[i], h_of[i]});
                end
                if (ov[i] && out_ready) begin
                    if (sbq[i].size() == 0) begin
                        check($sformatf("u%0d_spurious_out", i), 32'd1, 32'd0);
                    end else begin
                        e = sbq[i].pop_front();
                        check($sformatf("u%0d_sum", i), 32'(sm[i]), 32'(e.s));
                        check($sformatf("u%0d_carry", i), 32'(co[i]), 32'(e.co));
                        check($sformatf("u%0d_ovf", i), 32'(of[i]), 32'(e.ov));
                        if (e.lat) check($sformatf("u%0d_latency", i), 32'(ncyc - e.acc), 32'(stg[i]));
                    end
                end
                if (in_valid && ir[i]) begin
                    e     = model(a, b, c_in, sub);
                    e.acc = ncyc;
                    e.lat = lat_chk;
                    sbq[i].push_back(e);
                end
                held[i] = ov[i] && !out_ready;
                h_sm[i] = sm[i];
                h_co[i] = co[i];
                h_of[i] = of[i];
            end
        end
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
        int n = 0;
        a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        while (!ir[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        @(negedge clk);
        while (!ov[0] && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_dir(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                           input logic ts, input logic [15:0] es, input logic eco, input logic eov);
        do_op(ta, tb_, tc, ts);
        wait_out(tag);
        check({tag, "_sum"}, 32'(sm[0]), 32'(es));
        check({tag, "_carry"}, 32'(co[0]), 32'(eco));
        check({tag, "_ovf"}, 32'(of[0]), 32'(eov));
        @(posedge clk); #2;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) check($sformatf("u%0d_drained", i), 32'(sbq[i].size()), 32'd0);
    endtask

    initial begin
        exp_t        e;
        int          idx;
        int          stalled;
        int          n;
        logic [15:0] oa [8];
        logic [15:0] ob [8];
        logic        oc [8];
        logic        os [8];

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_rst_valid", i), 32'(ov[i]), 32'd0);
            check($sformatf("u%0d_rst_sum", i), 32'(sm[i]), 32'd0);
            check($sformatf("u%0d_rst_flags", i), {30'd0, co[i], of[i]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("u%0d_rst_in_ready", i), 32'(ir[i]), 32'd1);
        @(posedge clk); #2;

        lat_chk = 1'b1;
        run_dir("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_dir("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_dir("add_cin",  16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
        run_dir("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run_dir("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        drain(20);

        for (int k = 0; k < 60; k++) begin
            in_valid = ($urandom_range(0, 4) != 0);
            a = 16'($urandom); b = 16'($urandom);
            c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        drain(20);

        lat_chk = 1'b0;
        for (int k = 0; k < 80; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = 16'($urandom); b = 16'($urandom);
            c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain(20);

        for (int k = 0; k < 8; k++) begin
            oa[k] = 16'($urandom); ob[k] = 16'($urandom);
            oc[k] = 1'($urandom_range(0, 1)); os[k] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        stalled = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (idx < 8);
            if (idx < 8) begin
                a = oa[idx]; b = ob[idx]; c_in = oc[idx]; sub = os[idx];
            end
            @(negedge clk);
            if (ov[0] && !out_ready) begin
                stalled++;
                check("stall_in_ready", 32'(ir[0]), 32'd0);
            end
            if (in_valid && ir[0]) idx++;
            @(posedge clk); #2;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stall_accepted", 32'(idx), 32'd8);
        check("stall_cycles", 32'(stalled), 32'd3);
        drain(20);

        lat_chk = 1'b1;
        for (int k = 0; k < 4; k++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("rst_setup_timeout", 32'd1, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(ov[0]), 32'd0);
        check("rst_async_sum", 32'(sm[0]), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check($sformatf("u%0d_post_rst_quiet", i), 32'(ov[i]), 32'd0);
        end
        @(posedge clk); #2;
        a = 16'($urandom); b = 16'($urandom);
        e = model(a, b, 1'b1, 1'b1);
        run_dir("after_rst", a, b, 1'b1, 1'b1, e.s, e.co, e.ov);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
